prefetch_queue: RTL and testbench

//  Instruction prefetch queue (8086 BIU style) sitting upstream of the processor decoder.

---
 rtl/prefetch_queue.sv | 174 +++++++++++++++++
 tb/tb_prefetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue feeding the decoder one byte at a time.
// Words are fetched from code memory at CS:IP into a circular byte buffer.
// Each byte is handed out together with its IP. A flush discards the
// buffer and restarts fetching at a new CS:IP.
//
// Fetch FSM
//   state   | meaning
//   ST_IDLE | no fetch outstanding; may issue when space allows
//   ST_REQ  | fetch outstanding; m_req/m_addr held until m_ready
module prefetch_queue #(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_CS = 16'hFFFF,
    parameter logic [15:0] RESET_IP = 16'h0000,
    localparam int         CW       = $clog2(DEPTH + 1),
    localparam int         PW       = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [15:0]   i_cs,
    input  logic [15:0]   i_ip,
    input  logic          bus_busy,
    output logic          m_req,
    output logic [19:0]   m_addr,
    input  logic          m_ready,
    input  logic [15:0]   m_data,
    output logic          q_valid,
    output logic [7:0]    q_byte,
    output logic [15:0]   q_ip,
    input  logic          q_pop,
    output logic [CW-1:0] q_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_cs;
    logic [15:0]   r_fetch_ip;
    logic [15:0]   r_head_ip;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [7:0]    r_mem [DEPTH];

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_need;
    logic          w_space_ok;
    logic          w_capture;
    logic          w_pop;
    logic [CW-1:0] w_npush;
    logic [PW-1:0] w_tail_p1;
    logic [PW-1:0] w_tail_p2;
    logic [PW-1:0] w_head_p1;
    logic          w_we0;
    logic          w_we1;
    logic [7:0]    w_b0;
    logic [7:0]    w_b1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Space and handshake qualifiers shared by the FSM and datapath
    always_comb begin
        w_free     = DEPTH_C - r_count;
        w_need     = r_fetch_ip[0] ? CW'(1) : CW'(2);
        w_space_ok = (w_free >= w_need);
        w_capture  = (r_state == ST_REQ) && m_ready && !flush;
        w_pop      = q_pop && (r_count != '0) && !flush;
        w_npush    = w_capture ? w_need : '0;
        w_tail_p1  = ptr_inc(r_tail);
        w_tail_p2  = ptr_inc(w_tail_p1);
        w_head_p1  = ptr_inc(r_head);
    end

    // Fetch FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch FSM next-state logic; flush always returns to idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!flush && !bus_busy && w_space_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush || m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fetch FSM outputs
    always_comb begin
        m_req = (r_state == ST_REQ);
    end

    // Pointers, count, segment and IP tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs       <= RESET_CS;
            r_fetch_ip <= RESET_IP;
            r_head_ip  <= RESET_IP;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (flush) begin
            r_cs       <= i_cs;
            r_fetch_ip <= i_ip;
            r_head_ip  <= i_ip;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_count <= r_count + w_npush - CW'(w_pop);
            if (w_capture) begin
                r_fetch_ip <= r_fetch_ip + 16'(w_need);
                r_tail     <= r_fetch_ip[0] ? w_tail_p1 : w_tail_p2;
            end
            if (w_pop) begin
                r_head    <= w_head_p1;
                r_head_ip <= r_head_ip + 16'd1;
            end
        end
    end

    // Byte lane selection: odd fetch address keeps only the high byte
    always_comb begin
        w_we0 = w_capture;
        w_we1 = w_capture && !r_fetch_ip[0];
        w_b0  = r_fetch_ip[0] ? m_data[15:8] : m_data[7:0];
        w_b1  = m_data[15:8];
    end

    // Byte storage; contents are don't-care until written so no reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_we0 && (r_tail == PW'(i))) begin
                r_mem[i] <= w_b0;
            end
            if (w_we1 && (w_tail_p1 == PW'(i))) begin
                r_mem[i] <= w_b1;
            end
        end
    end

    // Decoder-facing and memory-facing outputs, all from registers
    always_comb begin
        q_valid = (r_count != '0);
        q_byte  = r_mem[r_head];
        q_ip    = r_head_ip;
        q_count = r_count;
        m_addr  = {r_cs, 4'h0} + {4'h0, r_fetch_ip};
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with hand-computed expectations.
module tb_prefetch_queue;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic [15:0] i_cs;
    logic [15:0] i_ip;
    logic        bus_busy;
    logic        m_req;
    logic [19:0] m_addr;
    logic        m_ready;
    logic [15:0] m_data;
    logic        q_valid;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic        q_pop;
    logic [2:0]  q_count;

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_ip;

    prefetch_queue dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .i_cs     (i_cs),
        .i_ip     (i_ip),
        .bus_busy (bus_busy),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .q_valid  (q_valid),
        .q_byte   (q_byte),
        .q_ip     (q_ip),
        .q_pop    (q_pop),
        .q_count  (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        i_cs     = 16'h0000;
        i_ip     = 16'h0000;
        bus_busy = 1'b0;
        m_ready  = 1'b1;
        m_data   = 16'h3412;
        q_pop    = 1'b0;
        exp_ip   = 16'h0000;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_req",   32'(m_req),   32'h0);
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_count", 32'(q_count), 32'h0);
        chk("rst_addr",  32'(m_addr),  32'hFFFF0);

        // 1: first fetch after reset
        reset_n = 1'b1;
        step();
        chk("t1_req",    32'(m_req),   32'h1);
        chk("t1_addr",   32'(m_addr),  32'hFFFF0);
        chk("t1_valid0", 32'(q_valid), 32'h0);
        step();
        chk("t1_valid",  32'(q_valid), 32'h1);
        chk("t1_byte0",  32'(q_byte),  32'h12);
        chk("t1_ip0",    32'(q_ip),    32'h0000);
        chk("t1_count",  32'(q_count), 32'h2);
        chk("t1_idle",   32'(m_req),   32'h0);
        q_pop = 1'b1;
        step();
        chk("t1_byte1",  32'(q_byte),  32'h34);
        chk("t1_ip1",    32'(q_ip),    32'h0001);
        chk("t1_count1", 32'(q_count), 32'h1);
        chk("t1_req2",   32'(m_req),   32'h1);
        chk("t1_addr2",  32'(m_addr),  32'hFFFF2);
        // request holds while memory stalls, even with bus_busy high
        q_pop    = 1'b0;
        m_ready  = 1'b0;
        bus_busy = 1'b1;
        step();
        step();
        chk("hold_req",  32'(m_req),   32'h1);
        chk("hold_addr", 32'(m_addr),  32'hFFFF2);

        // 5 + 2: flush with a fetch in flight and m_ready in the flush cycle
        flush    = 1'b1;
        i_cs     = 16'h1000;
        i_ip     = 16'h0003;
        m_data   = 16'hAB00;
        m_ready  = 1'b1;
        bus_busy = 1'b0;
        step();
        flush = 1'b0;
        chk("fl_count",  32'(q_count), 32'h0);
        chk("fl_valid",  32'(q_valid), 32'h0);
        chk("fl_req",    32'(m_req),   32'h0);
        chk("fl_addr",   32'(m_addr),  32'h10003);
        step();
        chk("t2_req",    32'(m_req),   32'h1);
        chk("t2_valid0", 32'(q_valid), 32'h0);
        step();
        chk("t2_valid",  32'(q_valid), 32'h1);
        chk("t2_byte",   32'(q_byte),  32'hAB);
        chk("t2_ip",     32'(q_ip),    32'h0003);
        chk("t2_count",  32'(q_count), 32'h1);
        chk("t2_addr",   32'(m_addr),  32'h10004);

        // 3: fill without pops
        m_data = 16'h3412;
        repeat (4) step();
        chk("t3_count5", 32'(q_count), 32'h5);
        repeat (3) step();
        chk("t3_noreq5", 32'(m_req),   32'h0);
        chk("t3_hold5",  32'(q_count), 32'h5);
        q_pop = 1'b1;
        step();
        q_pop = 1'b0;
        chk("t3_count4", 32'(q_count), 32'h4);
        chk("t3_noreq4", 32'(m_req),   32'h0);
        step();
        chk("t3_reissue", 32'(m_req),  32'h1);
        step();
        chk("t3_count6", 32'(q_count), 32'h6);
        chk("t3_head",   32'(q_byte),  32'h12);
        chk("t3_headip", 32'(q_ip),    32'h0004);
        repeat (3) step();
        chk("t3_full_req", 32'(m_req), 32'h0);
        chk("t3_full_cnt", 32'(q_count), 32'h6);

        // 4: pop every cycle while captures continue
        exp_ip = 16'h0004;
        q_pop  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_valid", 32'(q_valid), 32'h1);
            chk("t4_ip",    32'(q_ip),    32'(exp_ip));
            chk("t4_byte",  32'(q_byte),  32'(exp_ip[0] ? 8'h34 : 8'h12));
            chk("t4_le6",   32'(q_count <= 3'd6), 32'h1);
            step();
            exp_ip = exp_ip + 16'd1;
        end
        m_ready = 1'b0;
        for (int k = 0; k < 20 && q_count != 3'd0; k++) begin
            step();
            exp_ip = exp_ip + 16'd1;
        end
        chk("t4_drained", 32'(q_count), 32'h0);
        chk("t4_drip",    32'(q_ip),    32'(exp_ip));
        step();
        chk("t4_pop0_cnt", 32'(q_count), 32'h0);
        chk("t4_pop0_ip",  32'(q_ip),    32'(exp_ip));
        chk("t4_pop0_vld", 32'(q_valid), 32'h0);
        q_pop = 1'b0;

        // 6: flush to IP FFFF, wrap to 0000 within the segment
        flush   = 1'b1;
        i_cs    = 16'h2000;
        i_ip    = 16'hFFFF;
        m_data  = 16'hCDEF;
        m_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_addr",   32'(m_addr),  32'h2FFFF);
        chk("t6_count0", 32'(q_count), 32'h0);
        step();
        chk("t6_req",    32'(m_req),   32'h1);
        step();
        chk("t6_byte",   32'(q_byte),  32'hCD);
        chk("t6_ip",     32'(q_ip),    32'hFFFF);
        chk("t6_count",  32'(q_count), 32'h1);
        chk("t6_addr2",  32'(m_addr),  32'h20000);
        m_data = 16'h5678;
        q_pop  = 1'b1;
        step();
        q_pop = 1'b0;
        chk("t6_wrapip", 32'(q_ip),    32'h0000);
        chk("t6_cnt0",   32'(q_count), 32'h0);
        chk("t6_req2",   32'(m_req),   32'h1);
        step();
        chk("t6_byte2",  32'(q_byte),  32'h78);
        chk("t6_ip2",    32'(q_ip),    32'h0000);
        chk("t6_count2", 32'(q_count), 32'h2);

        // 7: bus_busy blocks issue; also 20-bit address carry is dropped
        flush    = 1'b1;
        i_cs     = 16'hFFFF;
        i_ip     = 16'h0010;
        bus_busy = 1'b1;
        step();
        flush = 1'b0;
        chk("t7_count",  32'(q_count), 32'h0);
        chk("t7_addr",   32'(m_addr),  32'h00000);
        repeat (3) step();
        chk("t7_busy",   32'(m_req),   32'h0);
        bus_busy = 1'b0;
        step();
        chk("t7_issue",  32'(m_req),   32'h1);
        chk("t7_addr2",  32'(m_addr),  32'h00000);

        // Asynchronous reset mid-run
        reset_n = 1'b0;
        #1;
        chk("arst_req",   32'(m_req),   32'h0);
        chk("arst_count", 32'(q_count), 32'h0);
        chk("arst_valid", 32'(q_valid), 32'h0);
        chk("arst_addr",  32'(m_addr),  32'hFFFF0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
